demux8_wbuf: RTL and testbench

- Write-side counterpart of the 8:1 16-bit read mux. Accepts (select, data) write requests through a valid/ready handshake.
- Buffers requests in a small in-order FIFO, then steers each one into one of eight 16-bit registers.
- The eight registers drive outputs a..h, so they can feed the 8:1 read mux directly.
- Keeps a per-register busy scoreboard so the issue stage can track registers with writes still outstanding.

---
 rtl/demux8_wbuf_pkg.sv | 25 ++
 rtl/demux8_wbuf_fifo.sv | 66 ++++++
 rtl/demux8_wbuf.sv | 119 +++++++++++
 tb/tb_demux8_wbuf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_wbuf_pkg.sv
// Shared definitions for the 8-register write buffer and its companion 8:1 read mux.
// Register index constants match the read mux select encoding.
package demux8_wbuf_pkg;

    localparam int NUM_REGS   = 8;
    localparam int SEL_W      = 3;
    localparam int DEF_DATA_W = 16;

    localparam logic [SEL_W-1:0] REG_A = 3'd0;
    localparam logic [SEL_W-1:0] REG_B = 3'd1;
    localparam logic [SEL_W-1:0] REG_C = 3'd2;
    localparam logic [SEL_W-1:0] REG_D = 3'd3;
    localparam logic [SEL_W-1:0] REG_E = 3'd4;
    localparam logic [SEL_W-1:0] REG_F = 3'd5;
    localparam logic [SEL_W-1:0] REG_G = 3'd6;
    localparam logic [SEL_W-1:0] REG_H = 3'd7;

    // Write-entry record at the default data width.
    // The FIFO stores the same layout flattened, so DATA_W can be overridden.
    typedef struct packed {
        logic [SEL_W-1:0]      sel;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/demux8_wbuf_fifo.sv
// In-order DEPTH-entry FIFO with push/pop, full/empty and occupancy count.
// The caller must not push when full or pop when empty.
module wbuf_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/demux8_wbuf.sv
// Buffered 1:8 write demux: queued (sel, data) writes retire in order into eight
// registers, with a per-register busy scoreboard and a one-cycle retire ack.
module demux8_wbuf
    import demux8_wbuf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              hold,
    input  logic              rsv_valid,
    input  logic [SEL_W-1:0]  rsv_sel,
    output logic [NUM_REGS-1:0] busy,
    output logic              wr_ack,
    output logic [SEL_W-1:0]  wr_ack_sel,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h
);

    localparam int ENTRY_W = SEL_W + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [SEL_W-1:0]   head_sel;
    logic [DATA_W-1:0]  head_data;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [SEL_W-1:0]    ack_sel_q, ack_sel_d;

    // Ready comes from registered occupancy only, so a full FIFO stays not-ready
    // even in a cycle where it also pops.
    assign wr_ready  = (fifo_count != CNT_W'(DEPTH));
    assign fifo_push = wr_valid && !fifo_full;
    assign fifo_pop  = !fifo_empty && !hold;
    assign head_sel  = head_entry[DATA_W +: SEL_W];
    assign head_data = head_entry[DATA_W-1:0];

    wbuf_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({wr_sel, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A reservation is applied after the retirement clear so that a same-index
    // reserve in the retiring cycle leaves the register busy.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        ack_sel_d = ack_sel_q;
        if (fifo_pop) begin
            regs_d[head_sel] = head_data;
            busy_d[head_sel] = 1'b0;
            ack_d            = 1'b1;
            ack_sel_d        = head_sel;
        end
        if (rsv_valid) begin
            busy_d[rsv_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            ack_q     <= 1'b0;
            ack_sel_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            ack_sel_q <= ack_sel_d;
        end
    end

    assign busy       = busy_q;
    assign wr_ack     = ack_q;
    assign wr_ack_sel = ack_sel_q;

    assign a = regs_q[REG_A];
    assign b = regs_q[REG_B];
    assign c = regs_q[REG_C];
    assign d = regs_q[REG_D];
    assign e = regs_q[REG_E];
    assign f = regs_q[REG_F];
    assign g = regs_q[REG_G];
    assign h = regs_q[REG_H];

endmodule

// File: tb/tb_demux8_wbuf.sv
// Directed self-checking bench for demux8_wbuf: reset, single write, hold/full,
// scoreboard races, back-to-back ordering with pointer wrap, and mid-flight reset.
module tb_demux8_wbuf;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        hold;
    logic        rsv_valid;
    logic [2:0]  rsv_sel;
    logic [7:0]  busy;
    logic        wr_ack;
    logic [2:0]  wr_ack_sel;
    logic [15:0] a, b, c, d, e, f, g, h;

    int checks   = 0;
    int failures = 0;

    demux8_wbuf #(.DATA_W(16), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .hold       (hold),
        .rsv_valid  (rsv_valid),
        .rsv_sel    (rsv_sel),
        .busy       (busy),
        .wr_ack     (wr_ack),
        .wr_ack_sel (wr_ack_sel),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g), .h (h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h1234;
        rsv_valid = 1'b1; rsv_sel = 3'd6;
        tick();
        wr_valid = 1'b0; rsv_valid = 1'b0;
        tick();
        checks++;
        if (c !== 16'h1234 || wr_ack !== 1'b1 || busy !== 8'h40) begin
            failures++;
            $display("[TB] FAIL pre_reset_state: c=%h ack=%b busy=%h, expected c=1234 ack=1 busy=40", c, wr_ack, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a, b, c, d, e, f, g, h} !== 128'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_regs: got %h expected 0", {a, b, c, d, e, f, g, h});
        end
        checks++;
        if (busy !== 8'h00 || wr_ready !== 1'b1 || wr_ack !== 1'b0 || wr_ack_sel !== 3'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_ctrl: busy=%h ready=%b ack=%b sel=%0d, expected 00 1 0 0", busy, wr_ready, wr_ack, wr_ack_sel);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (f !== 16'h0000 || wr_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_no_bypass: f=%h ack=%b, expected 0000 0", f, wr_ack);
        end
        tick();
        checks++;
        if (f !== 16'hBEEF || wr_ack !== 1'b1 || wr_ack_sel !== 3'd5) begin
            failures++;
            $display("[TB] FAIL single_retire: f=%h ack=%b sel=%0d, expected beef 1 5", f, wr_ack, wr_ack_sel);
        end
        checks++;
        if ({a, b, c, d, e, g, h} !== 112'd0 || busy !== 8'h00) begin
            failures++;
            $display("[TB] FAIL single_others: regs=%h busy=%h, expected 0 00", {a, b, c, d, e, g, h}, busy);
        end
        tick();
        checks++;
        if (wr_ack !== 1'b0 || f !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL single_ack_pulse: ack=%b f=%h, expected 0 beef", wr_ack, f);
        end
    endtask

    task automatic test_hold_full();
        int ack_count;
        hold = 1'b1;
        wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'h0001;
        tick();
        wr_sel = 3'd1; wr_data = 16'h0002;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_full_ready: got %b expected 0", wr_ready);
        end
        // Extra push while full must be dropped.
        wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h0033;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (a !== 16'h0 || b !== 16'h0 || f !== 16'hBEEF || wr_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_frozen: a=%h b=%h f=%h ack=%b, expected 0 0 beef 0", a, b, f, wr_ack);
        end
        hold = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_no_ready_through: got %b expected 0", wr_ready);
        end
        tick();
        checks++;
        if (a !== 16'h0001 || b !== 16'h0000 || wr_ack !== 1'b1 || wr_ack_sel !== 3'd0) begin
            failures++;
            $display("[TB] FAIL release_first: a=%h b=%h ack=%b sel=%0d, expected 1 0 1 0", a, b, wr_ack, wr_ack_sel);
        end
        tick();
        checks++;
        if (b !== 16'h0002 || wr_ack !== 1'b1 || wr_ack_sel !== 3'd1 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_second: b=%h ack=%b sel=%0d ready=%b, expected 2 1 1 1", b, wr_ack, wr_ack_sel, wr_ready);
        end
        ack_count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_ack === 1'b1) ack_count++;
        end
        checks++;
        if (ack_count != 0 || c !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL full_drop: extra acks=%0d c=%h, expected 0 0", ack_count, c);
        end
    endtask

    task automatic test_scoreboard_race();
        wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hD00D;
        rsv_valid = 1'b1; rsv_sel = 3'd4;
        tick();
        wr_sel = 3'd4; wr_data = 16'h4444;
        rsv_sel = 3'd3;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (busy !== 8'h18 || d !== 16'hD00D || wr_ack_sel !== 3'd3) begin
            failures++;
            $display("[TB] FAIL race_same_index: busy=%h d=%h sel=%0d, expected 18 d00d 3", busy, d, wr_ack_sel);
        end
        rsv_sel = 3'd2;
        tick();
        rsv_valid = 1'b0;
        checks++;
        if (busy !== 8'h0C || e !== 16'h4444 || wr_ack_sel !== 3'd4) begin
            failures++;
            $display("[TB] FAIL race_diff_index: busy=%h e=%h sel=%0d, expected 0c 4444 4", busy, e, wr_ack_sel);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int pushed;
        int acks;
        logic accepted;
        pushed = 0;
        acks = 0;
        wr_sel = 3'd7;
        for (int cyc = 0; cyc < 40 && acks < 10; cyc++) begin
            wr_valid = (pushed < 10);
            wr_data  = 16'(pushed + 1);
            #1;
            accepted = wr_valid && wr_ready;
            tick();
            if (accepted) pushed++;
            wr_valid = 1'b0;
            if (wr_ack === 1'b1) begin
                acks++;
                checks++;
                if (h !== 16'(acks) || wr_ack_sel !== 3'd7) begin
                    failures++;
                    $display("[TB] FAIL b2b_order: ack %0d h=%h sel=%0d, expected h=%h sel=7", acks, h, wr_ack_sel, 16'(acks));
                end
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (acks != 10 || pushed != 10) begin
            failures++;
            $display("[TB] FAIL b2b_count: acks=%0d pushed=%0d, expected 10 10", acks, pushed);
        end
        tick();
        checks++;
        if (h !== 16'd10 || wr_ack !== 1'b0 || busy !== 8'h0C) begin
            failures++;
            $display("[TB] FAIL b2b_final: h=%h ack=%b busy=%h, expected 000a 0 0c", h, wr_ack, busy);
        end
    endtask

    task automatic test_reset_midflight();
        int ack_count;
        hold = 1'b1;
        wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'hAAAA;
        tick();
        wr_sel = 3'd1; wr_data = 16'hBBBB;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflight_full: ready=%b expected 0", wr_ready);
        end
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        hold = 1'b0;
        ack_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack === 1'b1) ack_count++;
        end
        checks++;
        if (ack_count != 0) begin
            failures++;
            $display("[TB] FAIL midflight_no_ack: acks=%0d expected 0", ack_count);
        end
        checks++;
        if ({a, b, c, d, e, f, g, h} !== 128'd0 || busy !== 8'h00 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midflight_state: regs=%h busy=%h ready=%b, expected 0 00 1", {a, b, c, d, e, f, g, h}, busy, wr_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_valid = 1'b0; wr_sel = 3'd0; wr_data = 16'h0;
        hold = 1'b0; rsv_valid = 1'b0; rsv_sel = 3'd0;
        #12 reset = 1'b0;
        tick();
        test_reset();
        test_single_write();
        test_hold_full();
        test_scoreboard_race();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
